seq_window_monitor: RTL and testbench
=====================================

Name: seq_window_monitor

Overview:
- Synthesizable, multi-channel, run-time checker for the first-match temporal pattern a[*AMIN] |-> ##[DMIN:DMAX] b |=> c[*CMIN:CMAX].
- Brings our SVA checks into RTL so emulation and silicon debug see the same pass/fail events as simulation.
- Sits beside the DUT, samples its signals and reports per-channel verdicts, failure causes and saturating event counters.

Parameters:
- NCH, 4, number of independent channels.
- AMIN, 1, consecutive a cycles that complete the antecedent (>=1).
- DMIN, 1, earliest b offset after antecedent end (>=1).
- DMAX, 3, latest b offset (>=DMIN).
- CMIN, 1, required consecutive c cycles after b (>=1).
- CMAX, 2, maximum c run length; enforced only when STRICT_C=1 (>=CMIN).
- STRICT_C, 0, 1 = a c run longer than CMAX is a failure.
- CNT_W, 16, width of the saturating counters.

Ports:
- clk  in  1  sampling clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable. Low = all channels abort to IDLE silently.
- clr_cnt  in  1  synchronous clear of all counters.
- a  in  NCH  antecedent signal per channel.
- b  in  NCH  trigger signal per channel.
- c  in  NCH  consequent signal per channel.
- busy  out  NCH  channel has an attempt in progress.
- pass  out  NCH  one-cycle pass pulse.
- fail  out  NCH  one-cycle fail pulse.
- fail_code  out  2*NCH  cause, valid with fail: 01 no b in window, 10 c dropped early, 11 c over-run.
- pass_cnt  out  CNT_W  total passes, all channels.
- fail_cnt  out  CNT_W  total fails, all channels.

Behaviour:
- Reset: every output and all state go to 0; FSMs go to IDLE.
- All inputs are sampled at posedge clk. A decision made at edge n is registered and visible during the cycle after edge n.
- Per-channel FSM: IDLE, ANTE, WAITB, CONS. Counters: run (a run length), dly (b offset), ccnt (c run length).
- IDLE:
  - a=1 with AMIN=1: antecedent complete; go to WAITB with dly=0.
  - a=1 with AMIN>1: go to ANTE with run=1.
- ANTE:
  - a=0: return to IDLE, no report (vacuous).
  - a=1: run++. When run reaches AMIN, go to WAITB with dly=0.
  - First-match: longer a runs are never considered.
- WAITB:
  - Each edge: dly++. If b=1 and DMIN<=dly<=DMAX, go to CONS with ccnt=0.
  - b=1 with dly<DMIN is ignored.
  - dly reaches DMAX with no qualifying b: fail, code 01, return to IDLE.
  - First qualifying b wins.
- CONS (checking starts at the edge after b):
  - c=1: ccnt++.
  - c=0 with ccnt<CMIN: fail, code 10.
  - STRICT_C=0: ccnt reaching CMIN = pass.
  - STRICT_C=1: c=0 with CMIN<=ccnt<=CMAX = pass; c=1 at ccnt=CMAX+1 = fail, code 11.
- Any verdict returns the channel to IDLE. The a value sampled at the verdict edge is ignored.
- Attempts do not overlap: a while busy does not start a new thread.
- busy = (state != IDLE), registered.
- en=0: all channels go to IDLE next edge with no pass/fail. en does not gate clr_cnt.
- Counters add popcount(pass) and popcount(fail) each cycle and saturate at all-ones.
- clr_cnt=1 wins over a same-cycle increment; the counter reads 0 next cycle.
- rst mid-attempt: immediate abort, no verdict.
- Elaboration-time $error on any illegal parameter relation.
- Counter widths: run uses $clog2(AMIN+1), dly uses $clog2(DMAX+1), ccnt uses $clog2(CMAX+2).

Decomposition:
- Package seq_mon_pkg:
  - state enum (IDLE/ANTE/WAITB/CONS);
  - fail-code enum (FC_NONE/FC_NOB/FC_CSHORT/FC_COVER);
  - saturating-add function.
- Sub-module seq_mon_chan: one FSM plus its counters, instantiated NCH times in a generate loop.
- The top level holds the shared counters and popcount logic.

Test Plan:
- Defaults, ch0: a=1 at edge0, b=1 at edge2, c=1 at edge3 -> pass[0] high after edge3; pass_cnt=1; busy[0] high after edges 0-2.
- ch1: a=1 at edge0, b stays 0 through edge3 -> fail[1] after edge3, fail_code[3:2]=01, fail_cnt=1.
- b at edge1, c=0 at edge2 -> fail, code 10. Repeat with b at edge1 (dly=1 with DMIN=2) -> early b ignored; b at edge2 -> pass.
- STRICT_C=1, CMAX=2: c=1 at edges 3-5 -> fail, code 11 after edge5. c=1 at edges 3-4, 0 at edge5 -> pass after edge5.
- AMIN=2: a=1,0,1,1 -> first run vacuous; second run completes at edge3; a held high during WAITB starts no second attempt.
- All 4 channels pass in the same cycle -> pass_cnt +4. Preload pass_cnt near all-ones -> it saturates. clr_cnt in the same cycle -> 0. rst mid-WAITB -> busy clears asynchronously, no verdict.

Source files
------------

// File: rtl/seq_mon_pkg.sv
// Shared types and helpers for the seq_window_monitor temporal checker.
// Holds the per-channel FSM state, failure-cause encoding and counter arithmetic.
package seq_mon_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ANTE  = 2'd1,
      WAITB = 2'd2,
      CONS  = 2'd3
   } mon_state_e;

   typedef enum logic [1:0] {
      FC_NONE   = 2'b00,
      FC_NOB    = 2'b01,
      FC_CSHORT = 2'b10,
      FC_COVER  = 2'b11
   } fail_code_e;

   localparam int unsigned SAT_MAX_W = 32'd32;

   // Saturating add for counters of up to SAT_MAX_W bits; width selects the ceiling.
   function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                           input logic [31:0] inc,
                                           input int unsigned width);
      logic [32:0] sum_v;
      logic [32:0] max_v;
      max_v = (33'd1 << width) - 33'd1;
      sum_v = {1'b0, acc} + {1'b0, inc};
      if (sum_v > max_v) begin
         return max_v[31:0];
      end else begin
         return sum_v[31:0];
      end
   endfunction

endpackage

// File: rtl/seq_mon_chan.sv
// One checker thread for a[*AMIN] |-> ##[DMIN:DMAX] b |=> c[*CMIN:CMAX].
// First-match, non-overlapping; verdicts are registered one-cycle pulses.
module seq_mon_chan
   import seq_mon_pkg::*;
#(
   parameter int unsigned AMIN     = 32'd1,
   parameter int unsigned DMIN     = 32'd1,
   parameter int unsigned DMAX     = 32'd3,
   parameter int unsigned CMIN     = 32'd1,
   parameter int unsigned CMAX     = 32'd2,
   parameter int unsigned STRICT_C = 32'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   output logic       busy,
   output logic       pass,
   output logic       fail,
   output logic [1:0] fail_code
);

   localparam int unsigned RUN_W = $clog2(AMIN + 32'd1);
   localparam int unsigned DLY_W = $clog2(DMAX + 32'd1);
   localparam int unsigned CC_W  = $clog2(CMAX + 32'd2);

   localparam logic [RUN_W-1:0] AMIN_V    = RUN_W'(AMIN);
   localparam logic [DLY_W-1:0] DMIN_V    = DLY_W'(DMIN);
   localparam logic [DLY_W-1:0] DMAX_V    = DLY_W'(DMAX);
   localparam logic [CC_W-1:0]  CMIN_V    = CC_W'(CMIN);
   localparam logic [CC_W-1:0]  CMAX_P1_V = CC_W'(CMAX + 32'd1);
   localparam bit               AMIN_ONE  = (AMIN == 32'd1);
   localparam bit               STRICT    = (STRICT_C != 32'd0);

   mon_state_e       state_r, state_s;
   logic [RUN_W-1:0] run_r, run_s, run_inc_s;
   logic [DLY_W-1:0] dly_r, dly_s, dly_inc_s;
   logic [CC_W-1:0]  ccnt_r, ccnt_s, ccnt_inc_s;
   logic             busy_r, pass_r, fail_r, pass_s, fail_s;
   fail_code_e       code_r, code_s;

   // Next-state and verdict decode; any verdict or disable drops back to IDLE with cleared counters.
   always_comb begin
      state_s    = state_r;
      run_s      = run_r;
      dly_s      = dly_r;
      ccnt_s     = ccnt_r;
      pass_s     = 1'b0;
      fail_s     = 1'b0;
      code_s     = FC_NONE;
      run_inc_s  = run_r + RUN_W'(1);
      dly_inc_s  = dly_r + DLY_W'(1);
      ccnt_inc_s = ccnt_r + CC_W'(1);

      if (!en) begin
         state_s = IDLE;
         run_s   = {RUN_W{1'b0}};
         dly_s   = {DLY_W{1'b0}};
         ccnt_s  = {CC_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (a && AMIN_ONE) begin
                  state_s = WAITB;
                  dly_s   = {DLY_W{1'b0}};
               end else if (a) begin
                  state_s = ANTE;
                  run_s   = RUN_W'(1);
               end else begin
                  state_s = IDLE;
               end
            end
            ANTE: begin
               if (!a) begin
                  state_s = IDLE;
                  run_s   = {RUN_W{1'b0}};
               end else if (run_inc_s == AMIN_V) begin
                  state_s = WAITB;
                  run_s   = {RUN_W{1'b0}};
                  dly_s   = {DLY_W{1'b0}};
               end else begin
                  run_s = run_inc_s;
               end
            end
            WAITB: begin
               // dly never passes DMAX, so the upper window bound is implied by the timeout below.
               if (b && (dly_inc_s >= DMIN_V)) begin
                  state_s = CONS;
                  dly_s   = {DLY_W{1'b0}};
                  ccnt_s  = {CC_W{1'b0}};
               end else if (dly_inc_s >= DMAX_V) begin
                  state_s = IDLE;
                  dly_s   = {DLY_W{1'b0}};
                  fail_s  = 1'b1;
                  code_s  = FC_NOB;
               end else begin
                  dly_s = dly_inc_s;
               end
            end
            CONS: begin
               if (c && !STRICT && (ccnt_inc_s == CMIN_V)) begin
                  state_s = IDLE;
                  ccnt_s  = {CC_W{1'b0}};
                  pass_s  = 1'b1;
               end else if (c && STRICT && (ccnt_inc_s == CMAX_P1_V)) begin
                  state_s = IDLE;
                  ccnt_s  = {CC_W{1'b0}};
                  fail_s  = 1'b1;
                  code_s  = FC_COVER;
               end else if (c) begin
                  ccnt_s = ccnt_inc_s;
               end else if (ccnt_r < CMIN_V) begin
                  state_s = IDLE;
                  ccnt_s  = {CC_W{1'b0}};
                  fail_s  = 1'b1;
                  code_s  = FC_CSHORT;
               end else begin
                  state_s = IDLE;
                  ccnt_s  = {CC_W{1'b0}};
                  pass_s  = 1'b1;
               end
            end
            default: begin
               state_s = IDLE;
               run_s   = {RUN_W{1'b0}};
               dly_s   = {DLY_W{1'b0}};
               ccnt_s  = {CC_W{1'b0}};
            end
         endcase
      end
   end

   // State, counters and registered outputs; busy reflects the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         run_r   <= {RUN_W{1'b0}};
         dly_r   <= {DLY_W{1'b0}};
         ccnt_r  <= {CC_W{1'b0}};
         busy_r  <= 1'b0;
         pass_r  <= 1'b0;
         fail_r  <= 1'b0;
         code_r  <= FC_NONE;
      end else begin
         state_r <= state_s;
         run_r   <= run_s;
         dly_r   <= dly_s;
         ccnt_r  <= ccnt_s;
         busy_r  <= (state_s != IDLE);
         pass_r  <= pass_s;
         fail_r  <= fail_s;
         code_r  <= code_s;
      end
   end

   assign busy      = busy_r;
   assign pass      = pass_r;
   assign fail      = fail_r;
   assign fail_code = code_r;

endmodule

// File: rtl/seq_window_monitor.sv
// Multi-channel run-time checker: NCH independent pattern threads plus
// shared saturating pass/fail event counters.
module seq_window_monitor
   import seq_mon_pkg::*;
#(
   parameter int unsigned NCH      = 32'd4,
   parameter int unsigned AMIN     = 32'd1,
   parameter int unsigned DMIN     = 32'd1,
   parameter int unsigned DMAX     = 32'd3,
   parameter int unsigned CMIN     = 32'd1,
   parameter int unsigned CMAX     = 32'd2,
   parameter int unsigned STRICT_C = 32'd0,
   parameter int unsigned CNT_W    = 32'd16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               clr_cnt,
   input  logic [NCH-1:0]     a,
   input  logic [NCH-1:0]     b,
   input  logic [NCH-1:0]     c,
   output logic [NCH-1:0]     busy,
   output logic [NCH-1:0]     pass,
   output logic [NCH-1:0]     fail,
   output logic [2*NCH-1:0]   fail_code,
   output logic [CNT_W-1:0]   pass_cnt,
   output logic [CNT_W-1:0]   fail_cnt
);

   localparam int unsigned POP_W = $clog2(NCH + 32'd1);

   if ((NCH < 32'd1) || (AMIN < 32'd1) || (DMIN < 32'd1) || (DMAX < DMIN) ||
       (CMIN < 32'd1) || (CMAX < CMIN) || (STRICT_C > 32'd1) ||
       (CNT_W < 32'd1) || (CNT_W > SAT_MAX_W)) begin : g_bad_param
      $error("seq_window_monitor: illegal parameter relation");
   end

   logic [NCH-1:0]   busy_s, pass_s, fail_s;
   logic [2*NCH-1:0] code_s;
   logic [POP_W-1:0] pass_pop_s, fail_pop_s;
   logic [CNT_W-1:0] pass_cnt_r, fail_cnt_r;

   for (genvar g = 32'd0; g < NCH; g = g + 32'd1) begin : g_chan
      seq_mon_chan #(
         .AMIN     (AMIN),
         .DMIN     (DMIN),
         .DMAX     (DMAX),
         .CMIN     (CMIN),
         .CMAX     (CMAX),
         .STRICT_C (STRICT_C)
      ) u_chan (
         .clk       (clk),
         .rst       (rst),
         .en        (en),
         .a         (a[g]),
         .b         (b[g]),
         .c         (c[g]),
         .busy      (busy_s[g]),
         .pass      (pass_s[g]),
         .fail      (fail_s[g]),
         .fail_code (code_s[2*g +: 2])
      );
   end

   // Count this cycle's registered verdict pulses across all channels.
   always_comb begin
      pass_pop_s = {POP_W{1'b0}};
      fail_pop_s = {POP_W{1'b0}};
      for (int unsigned i = 32'd0; i < NCH; i++) begin
         pass_pop_s = pass_pop_s + POP_W'(pass_s[i]);
         fail_pop_s = fail_pop_s + POP_W'(fail_s[i]);
      end
   end

   // Shared event counters; clear takes priority over a same-cycle increment.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pass_cnt_r <= {CNT_W{1'b0}};
         fail_cnt_r <= {CNT_W{1'b0}};
      end else if (clr_cnt) begin
         pass_cnt_r <= {CNT_W{1'b0}};
         fail_cnt_r <= {CNT_W{1'b0}};
      end else begin
         pass_cnt_r <= CNT_W'(sat_add(32'(pass_cnt_r), 32'(pass_pop_s), CNT_W));
         fail_cnt_r <= CNT_W'(sat_add(32'(fail_cnt_r), 32'(fail_pop_s), CNT_W));
      end
   end

   assign busy      = busy_s;
   assign pass      = pass_s;
   assign fail      = fail_s;
   assign fail_code = code_s;
   assign pass_cnt  = pass_cnt_r;
   assign fail_cnt  = fail_cnt_r;

endmodule

// File: tb/tb_seq_window_monitor.sv
// Directed bench for seq_window_monitor: a default instance and an
// AMIN=2/DMIN=2/STRICT_C=1/CNT_W=3 instance, driven one edge at a time.
module tb_seq_window_monitor;

   logic       clk = 1'b0;
   logic       rst, en, clr_cnt;
   logic [3:0] a0, b0, c0, a1, b1, c1;
   logic [3:0] busy0, pass0, fail0, busy1, pass1, fail1;
   logic [7:0] code0, code1;
   logic [15:0] pcnt0, fcnt0;
   logic [2:0]  pcnt1, fcnt1;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_window_monitor u_def (
      .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
      .a(a0), .b(b0), .c(c0),
      .busy(busy0), .pass(pass0), .fail(fail0), .fail_code(code0),
      .pass_cnt(pcnt0), .fail_cnt(fcnt0)
   );

   seq_window_monitor #(
      .NCH(32'd4), .AMIN(32'd2), .DMIN(32'd2), .DMAX(32'd3),
      .CMIN(32'd1), .CMAX(32'd2), .STRICT_C(32'd1), .CNT_W(32'd3)
   ) u_alt (
      .clk(clk), .rst(rst), .en(en), .clr_cnt(clr_cnt),
      .a(a1), .b(b1), .c(c1),
      .busy(busy1), .pass(pass1), .fail(fail1), .fail_code(code1),
      .pass_cnt(pcnt1), .fail_cnt(fcnt1)
   );

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // All four alt channels: a for two edges, b at offset 2, one c, then c low -> pass.
   task automatic alt_pass4();
      a1 = 4'hF; tick(); tick();
      a1 = 4'h0; tick();
      b1 = 4'hF; tick();
      b1 = 4'h0; c1 = 4'hF; tick();
      c1 = 4'h0; tick();
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; clr_cnt = 1'b0;
      a0 = 4'h0; b0 = 4'h0; c0 = 4'h0;
      a1 = 4'h0; b1 = 4'h0; c1 = 4'h0;
      tick(); tick();
      chk_eq("rst_busy0", 32'(busy0), 32'h0);
      chk_eq("rst_pass0", 32'(pass0), 32'h0);
      chk_eq("rst_fail0", 32'(fail0), 32'h0);
      chk_eq("rst_code0", 32'(code0), 32'h0);
      chk_eq("rst_pcnt0", 32'(pcnt0), 32'h0);
      chk_eq("rst_fcnt0", 32'(fcnt0), 32'h0);
      chk_eq("rst_busy1", 32'(busy1), 32'h0);
      rst = 1'b0;
      tick();

      // ch0 pass: a@e0, b@e2, c@e3
      a0 = 4'b0001; tick();
      chk_eq("p_busy_e0", 32'(busy0), 32'h1);
      a0 = 4'h0; tick();
      chk_eq("p_busy_e1", 32'(busy0), 32'h1);
      b0 = 4'b0001; tick();
      chk_eq("p_busy_e2", 32'(busy0), 32'h1);
      chk_eq("p_pass_e2", 32'(pass0), 32'h0);
      b0 = 4'h0; c0 = 4'b0001; tick();
      chk_eq("p_pass_e3", 32'(pass0), 32'h1);
      chk_eq("p_busy_e3", 32'(busy0), 32'h0);
      c0 = 4'h0; tick();
      chk_eq("p_pulse", 32'(pass0), 32'h0);
      chk_eq("p_pcnt", 32'(pcnt0), 32'h1);

      // ch1 no b in window -> code 01
      a0 = 4'b0010; tick();
      a0 = 4'h0; tick(); tick();
      chk_eq("nob_e2", 32'(fail0), 32'h0);
      tick();
      chk_eq("nob_fail", 32'(fail0), 32'h2);
      chk_eq("nob_code", 32'(code0), 32'h04);
      tick();
      chk_eq("nob_fcnt", 32'(fcnt0), 32'h1);
      chk_eq("nob_code_clr", 32'(code0), 32'h0);

      // ch2 b@e1 then c low -> code 10
      a0 = 4'b0100; tick();
      a0 = 4'h0; b0 = 4'b0100; tick();
      b0 = 4'h0; tick();
      chk_eq("cshort_fail", 32'(fail0), 32'h4);
      chk_eq("cshort_code", 32'(code0), 32'h20);
      tick();
      chk_eq("cshort_fcnt", 32'(fcnt0), 32'h2);

      // all four channels pass together
      a0 = 4'hF; tick();
      a0 = 4'h0; b0 = 4'hF; tick();
      b0 = 4'h0; c0 = 4'hF; tick();
      chk_eq("all4_pass", 32'(pass0), 32'hF);
      c0 = 4'h0; tick();
      chk_eq("all4_pcnt", 32'(pcnt0), 32'h5);

      // en low aborts silently
      a0 = 4'b1000; tick();
      chk_eq("en_busy", 32'(busy0), 32'h8);
      a0 = 4'h0; en = 1'b0; tick();
      chk_eq("en_abort", 32'(busy0), 32'h0);
      en = 1'b1; tick(); tick();
      chk_eq("en_nofail", 32'(fail0), 32'h0);
      tick();
      chk_eq("en_fcnt", 32'(fcnt0), 32'h2);

      // alt ch0: b at dly=1 ignored, b at dly=2 taken, c then c low -> pass
      a1 = 4'b0001; tick();
      chk_eq("eb_busy_ante", 32'(busy1), 32'h1);
      tick();
      a1 = 4'h0; b1 = 4'b0001; tick();
      tick();
      chk_eq("eb_ignored", 32'(fail1), 32'h0);
      chk_eq("eb_busy", 32'(busy1), 32'h1);
      b1 = 4'h0; c1 = 4'b0001; tick();
      chk_eq("eb_nopass_yet", 32'(pass1), 32'h0);
      c1 = 4'h0; tick();
      chk_eq("eb_pass", 32'(pass1), 32'h1);

      // alt ch0: three c cycles with CMAX=2 -> code 11
      a1 = 4'b0001; tick(); tick();
      a1 = 4'h0; tick();
      b1 = 4'b0001; tick();
      b1 = 4'h0; c1 = 4'b0001; tick(); tick();
      chk_eq("cover_e5", 32'(fail1), 32'h0);
      chk_eq("cover_nopass", 32'(pass1), 32'h0);
      tick();
      chk_eq("cover_fail", 32'(fail1), 32'h1);
      chk_eq("cover_code", 32'(code1), 32'h03);
      c1 = 4'h0; tick();

      // alt ch0: two c cycles then low -> pass
      a1 = 4'b0001; tick(); tick();
      a1 = 4'h0; tick();
      b1 = 4'b0001; tick();
      b1 = 4'h0; c1 = 4'b0001; tick(); tick();
      c1 = 4'h0; tick();
      chk_eq("c2_pass", 32'(pass1), 32'h1);
      chk_eq("c2_nofail", 32'(fail1), 32'h0);

      // alt ch0 AMIN=2: a=1,0,1,1 then a held high through WAITB
      a1 = 4'b0001; tick();
      a1 = 4'h0; tick();
      chk_eq("ante_vacuous", 32'(busy1), 32'h0);
      chk_eq("ante_nofail", 32'(fail1), 32'h0);
      a1 = 4'b0001; tick();
      chk_eq("ante_busy", 32'(busy1), 32'h1);
      tick(); tick(); tick();
      chk_eq("ante_e5", 32'(fail1), 32'h0);
      tick();
      chk_eq("ante_fail", 32'(fail1), 32'h1);
      chk_eq("ante_code", 32'(code1), 32'h01);
      chk_eq("ante_idle", 32'(busy1), 32'h0);
      a1 = 4'h0; tick();
      chk_eq("ante_nothread", 32'(busy1), 32'h0);
      chk_eq("alt_pcnt", 32'(pcnt1), 32'h2);
      chk_eq("alt_fcnt", 32'(fcnt1), 32'h2);

      // 3-bit counter: +4 -> 6, +4 -> saturate at 7, then clear beats increment
      alt_pass4();
      chk_eq("sat_pass4", 32'(pass1), 32'hF);
      tick();
      chk_eq("sat_6", 32'(pcnt1), 32'h6);
      alt_pass4();
      tick();
      chk_eq("sat_7", 32'(pcnt1), 32'h7);
      alt_pass4();
      clr_cnt = 1'b1; tick();
      clr_cnt = 1'b0;
      chk_eq("clr_pcnt1", 32'(pcnt1), 32'h0);
      chk_eq("clr_fcnt1", 32'(fcnt1), 32'h0);
      chk_eq("clr_pcnt0", 32'(pcnt0), 32'h0);

      // reset mid-WAITB: busy clears without a clock edge, no verdict later
      a0 = 4'b0001; tick();
      chk_eq("rstw_busy", 32'(busy0), 32'h1);
      a0 = 4'h0;
      #2 rst = 1'b1;
      #1;
      chk_eq("rstw_async", 32'(busy0), 32'h0);
      rst = 1'b0;
      tick(); tick(); tick();
      chk_eq("rstw_nofail", 32'(fail0), 32'h0);
      chk_eq("rstw_idle", 32'(busy0), 32'h0);
      tick();
      chk_eq("rstw_fcnt", 32'(fcnt0), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
